// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a sign-fix cycle).
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e            state;
  logic [WIDTH-1:0]  rem, q, d;
  logic [CntW-1:0]   cnt;
  logic [WIDTH:0]    shifted, diff;
  logic [WIDTH-1:0]  rem_next, q_next;
  logic [WIDTH-1:0]  dvd_mag, dvs_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  assign dvd_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign dvs_mag = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
`else
  assign dvd_mag = Dividend;
  assign dvs_mag = Divisor;
`endif

  // Partial remainder is kept W+1 bits wide so large divisors cannot overflow the shift.
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    diff    = shifted - {1'b0, d};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= StIdle;
      rem       <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        StIdle: begin
          if (Start) begin
            if (Divisor == '0) begin
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
              Done      <= 1'b1;
              state     <= StDone;
            end else begin
              rem       <= '0;
              q         <= dvd_mag;
              d         <= dvs_mag;
              cnt       <= CntW'(WIDTH - 1);
              DivByZero <= 1'b0;
              Busy      <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
              neg_q     <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
              neg_r     <= Dividend[WIDTH-1];
`endif
              state     <= StRun;
            end
          end
        end
        StRun: begin
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            state     <= StFix;
`else
            Quotient  <= q_next;
            Remainder <= rem_next;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            state     <= StDone;
`endif
          end
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        StFix: begin
          Quotient  <= neg_q ? -q : q;
          Remainder <= neg_r ? -rem : rem;
          Busy      <= 1'b0;
          Done      <= 1'b1;
          state     <= StDone;
        end
`endif
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes model results, monitor checks on Done.
module tb_seq_divider;

  localparam int W = 16;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int Lat = W + 1;
`else
  localparam int Lat = W;
`endif

  logic         clk, rst, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, dbz;
  logic [W-1:0] quo, rem;

  seq_divider #(.WIDTH(W)) dut (
    .Clk      (clk),
    .Reset    (rst),
    .Start    (start),
    .Dividend (dividend),
    .Divisor  (divisor),
    .Busy     (busy),
    .Done     (done),
    .DivByZero(dbz),
    .Quotient (quo),
    .Remainder(rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           done_at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_from = 0;
  int   busy_until = 0;
  bit   fin = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
    int sa, sbv;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa  = int'($signed(a));
      sbv = int'($signed(b));
`else
      sa  = int'({16'd0, a});
      sbv = int'({16'd0, b});
`endif
      e.q = W'(sa / sbv);
      e.r = W'(sa % sbv);
      e.z = 1'b0;
    end
  endtask

  // Called at a negedge with the DUT idle; returns just after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    model(a, b, e);
    lat = (b == '0) ? 0 : Lat;
    e.done_at = cyc + lat;
    sb.push_back(e);
    busy_from  = cyc;
    busy_until = cyc + lat;
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    issue(a, b, lat);
    repeat (lat + 2) @(negedge clk);
  endtask

  initial begin
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst      = 1'b1;
    fork
      begin : driver
        int   lat;
        logic [W-1:0] a, b;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_dbz", {31'd0, dbz}, 32'd0);
        chk("reset_quo", {16'd0, quo}, 32'd0);
        chk("reset_rem", {16'd0, rem}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(16'd100, 16'd7);
        run(16'hFFFF, 16'd1);
        run(16'd3, 16'hFFFF);
        run(16'd5, 16'd0);
        run(16'd9, 16'd3);
        run(16'hFFF9, 16'd2);
        run(16'h8000, 16'hFFFF);

        // Start pulse mid-run must be ignored.
        issue(16'd100, 16'd7, lat);
        repeat (7) @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (lat + 2 - 8) @(negedge clk);

        // Reset in the middle of a divide abandons it with no Done.
        issue(16'd1000, 16'd3, lat);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        busy_until = 0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_quo", {16'd0, quo}, 32'd0);
        chk("midrst_rem", {16'd0, rem}, 32'd0);
        chk("midrst_dbz", {31'd0, dbz}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        run(16'd1000, 16'd3);

        for (int i = 0; i < 40; i++) begin
          a = W'($urandom);
          case ($urandom_range(0, 9))
            0:       b = '0;
            1, 2, 3: b = W'($urandom_range(1, 15));
            4:       b = W'($urandom) | 16'h8000;
            default: b = W'($urandom);
          endcase
          run(a, b);
        end
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        fin = 1'b1;
      end
      begin : monitor
        exp_t e;
        logic exp_busy;
        while (!fin) begin
          @(negedge clk);
          if (!rst) begin
            exp_busy = (cyc >= busy_from) && (cyc < busy_until);
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (done) begin
              if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
              end else begin
                e = sb.pop_front();
                chk("quotient", {16'd0, quo}, {16'd0, e.q});
                chk("remainder", {16'd0, rem}, {16'd0, e.r});
                chk("divbyzero", {31'd0, dbz}, {31'd0, e.z});
                chk("done_cycle", cyc, e.done_at);
              end
            end else if (sb.size() > 0 && cyc > sb[0].done_at) begin
              e = sb.pop_front();
              checks++;
              errors++;
              $display("FAIL done_timeout: got no done expected at cycle %0d", e.done_at);
            end
          end
        end
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
